// File: rtl/kpad_pkg.sv
// Shared types, the standard 4x4 key map and the key decode helper for the keypad digit buffer.
package kpad_pkg;

  typedef enum logic {
    IDLE,
    HELD
  } kpad_state_t;

  // Nibble k holds the code for key index row*4+col; nibble 0 sits in the LSBs.
  localparam logic [63:0] KPAD_MAP4 = 64'hDF0E_C987_B654_A321;

  function automatic int unsigned kpad_decode(input int unsigned r_idx,
                                              input int unsigned c_idx,
                                              input int unsigned rows,
                                              input int unsigned cols);
    if (rows == 4 && cols == 4) begin
      return {28'd0, KPAD_MAP4[(r_idx * 4 + c_idx) * 4 +: 4]};
    end
    return r_idx * cols + c_idx;
  endfunction

endpackage

// File: rtl/kpad_onehot_enc.sv
// One-hot to binary index encoder with one-hot and all-zero flags.
module kpad_onehot_enc #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             one_hot,
  output logic             zero
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign zero    = (vec == '0);
  assign one_hot = !zero && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/kpad_digit_buffer.sv
// Keypad decoder with a DEPTH-deep digit history, press/release tracking and multi-key errors.
// Optional history-clear key enabled by defining KPAD_CLEAR_EN.
module kpad_digit_buffer
  import kpad_pkg::*;
#(
  parameter int               ROWS       = 4,
  parameter int               COLS       = 4,
  parameter int               DEPTH      = 2,
  parameter int               CODE_W     = 4,
  parameter logic [CODE_W-1:0] CLEAR_CODE = 4'hE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ROWS-1:0]               row,
  input  logic [COLS-1:0]               col,
  input  logic                          enable,
  output logic [DEPTH*CODE_W-1:0]       digits,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [CODE_W-1:0]             key_code,
  output logic                          key_valid,
  output logic                          multi_err
);

  localparam int DIG_W  = DEPTH * CODE_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;

`ifdef KPAD_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic [RIDX_W-1:0] row_idx;
  logic [CIDX_W-1:0] col_idx;
  logic              row_oh, row_zero;
  logic              col_oh, col_zero;

  kpad_onehot_enc #(.N(ROWS)) u_row_enc (
    .vec     (row),
    .idx     (row_idx),
    .one_hot (row_oh),
    .zero    (row_zero)
  );

  kpad_onehot_enc #(.N(COLS)) u_col_enc (
    .vec     (col),
    .idx     (col_idx),
    .one_hot (col_oh),
    .zero    (col_zero)
  );

  logic [CODE_W-1:0] code;
  logic              is_valid, is_release, is_multi, clear_hit;

  assign code       = CODE_W'(kpad_decode(32'(row_idx), 32'(col_idx), ROWS, COLS));
  assign is_valid   = row_oh && col_oh;
  assign is_release = row_zero;
  // Anything with an active row that is not a clean single key is a multi-key sample.
  assign is_multi   = !row_zero && (col_zero || !is_valid);
  assign clear_hit  = CLEAR_EN && (code == CLEAR_CODE);

  kpad_state_t       state_q, state_d;
  logic [DIG_W-1:0]  digits_q, digits_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              multi_err_q, multi_err_d;

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    count_d     = count_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    multi_err_d = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (is_valid) begin
            key_code_d  = code;
            key_valid_d = 1'b1;
            state_d     = HELD;
            if (clear_hit) begin
              digits_d = '0;
              count_d  = '0;
            end else begin
              digits_d = (digits_q << CODE_W) | DIG_W'(code);
              if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
            end
          end else if (is_multi) begin
            multi_err_d = 1'b1;
          end
        end
        HELD: begin
          // No rollover: a new key is only taken after a release sample.
          if (is_release) begin
            state_d = IDLE;
          end else if (is_multi) begin
            multi_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      count_q     <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign digits    = digits_q;
  assign count     = count_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign multi_err = multi_err_q;

endmodule

// File: tb/tb_kpad_digit_buffer.sv
// Self-checking bench: three keypad buffers (4x4 depth 2, 4x4 depth 3, 3x5 depth 1) against a history model.
module tb_kpad_digit_buffer;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] rowAB, colAB;
  logic       enAB;
  logic [2:0] rowC;
  logic [4:0] colC;
  logic       enC;

  logic [7:0]  digitsA;
  logic [1:0]  countA;
  logic [3:0]  keyCodeA;
  logic        keyValidA, multiErrA;
  logic [11:0] digitsB;
  logic [1:0]  countB;
  logic [3:0]  keyCodeB;
  logic        keyValidB, multiErrB;
  logic [3:0]  digitsC;
  logic [0:0]  countC;
  logic [3:0]  keyCodeC;
  logic        keyValidC, multiErrC;

  always #5 clk = ~clk;

  kpad_digit_buffer dutA (
    .clk(clk), .reset(reset), .row(rowAB), .col(colAB), .enable(enAB),
    .digits(digitsA), .count(countA), .key_code(keyCodeA),
    .key_valid(keyValidA), .multi_err(multiErrA)
  );

  kpad_digit_buffer #(.DEPTH(3)) dutB (
    .clk(clk), .reset(reset), .row(rowAB), .col(colAB), .enable(enAB),
    .digits(digitsB), .count(countB), .key_code(keyCodeB),
    .key_valid(keyValidB), .multi_err(multiErrB)
  );

  kpad_digit_buffer #(.ROWS(3), .COLS(5), .DEPTH(1)) dutC (
    .clk(clk), .reset(reset), .row(rowC), .col(colC), .enable(enC),
    .digits(digitsC), .count(countC), .key_code(keyCodeC),
    .key_valid(keyValidC), .multi_err(multiErrC)
  );

`ifdef KPAD_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;

  int geoRows[3]  = '{4, 4, 3};
  int geoCols[3]  = '{4, 4, 5};
  int geoDepth[3] = '{2, 3, 1};
  int map4[16]    = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int hist[3][4];
  int cnt[3];
  bit held[3];
  int kcode[3];
  bit kv[3];
  bit me[3];

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) hist[i][j] = 0;
      cnt[i] = 0; held[i] = 0; kcode[i] = 0; kv[i] = 0; me[i] = 0;
    end
  endtask

  task automatic modelStep(input int i, input int r, input int c, input bit en);
    int code;
    kv[i] = 0;
    me[i] = 0;
    if (!en) return;
    if ($countones(r) == 1 && $countones(c) == 1) begin
      if (!held[i]) begin
        if (geoRows[i] == 4 && geoCols[i] == 4) code = map4[$clog2(r) * 4 + $clog2(c)];
        else code = $clog2(r) * geoCols[i] + $clog2(c);
        kcode[i] = code;
        kv[i]    = 1;
        held[i]  = 1;
        if (ClearEn && code == 14) begin
          for (int j = 0; j < 4; j++) hist[i][j] = 0;
          cnt[i] = 0;
        end else begin
          for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
          hist[i][0] = code;
          if (cnt[i] < geoDepth[i]) cnt[i]++;
        end
      end
    end else if (r == 0) begin
      held[i] = 0;
    end else begin
      me[i] = 1;
    end
  endtask

  function automatic logic [31:0] expDigits(input int i);
    logic [31:0] v = 0;
    for (int j = 0; j < geoDepth[i]; j++) v |= 32'(hist[i][j]) << (4 * j);
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, "/A.digits"},    32'(digitsA),   expDigits(0));
    cmp({tag, "/A.count"},     32'(countA),    32'(cnt[0]));
    cmp({tag, "/A.key_code"},  32'(keyCodeA),  32'(kcode[0]));
    cmp({tag, "/A.key_valid"}, 32'(keyValidA), 32'(kv[0]));
    cmp({tag, "/A.multi_err"}, 32'(multiErrA), 32'(me[0]));
    cmp({tag, "/B.digits"},    32'(digitsB),   expDigits(1));
    cmp({tag, "/B.count"},     32'(countB),    32'(cnt[1]));
    cmp({tag, "/B.key_code"},  32'(keyCodeB),  32'(kcode[1]));
    cmp({tag, "/B.key_valid"}, 32'(keyValidB), 32'(kv[1]));
    cmp({tag, "/B.multi_err"}, 32'(multiErrB), 32'(me[1]));
    cmp({tag, "/C.digits"},    32'(digitsC),   expDigits(2));
    cmp({tag, "/C.count"},     32'(countC),    32'(cnt[2]));
    cmp({tag, "/C.key_code"},  32'(keyCodeC),  32'(kcode[2]));
    cmp({tag, "/C.key_valid"}, 32'(keyValidC), 32'(kv[2]));
    cmp({tag, "/C.multi_err"}, 32'(multiErrC), 32'(me[2]));
  endtask

  // Random sample: mostly clean single keys, some releases, some multi-key patterns.
  task automatic genSample(input int rows, input int cols, output int r, output int c);
    int k = $urandom_range(0, 9);
    int rmask = (1 << rows) - 1;
    int cmask = (1 << cols) - 1;
    if (k < 5) begin
      r = 1 << $urandom_range(0, rows - 1);
      c = 1 << $urandom_range(0, cols - 1);
    end else if (k < 7) begin
      r = 0;
      c = 0;
    end else begin
      r = int'($urandom) & rmask;
      c = int'($urandom) & cmask;
      if (r == 0 || ($countones(r) == 1 && $countones(c) == 1)) r = rmask;
    end
  endtask

  // Called at a falling edge: drive, let the rising edge sample, then check at the next falling edge.
  task automatic applyStimulus(input int rAB, input int cAB, input bit eAB,
                               input int rC, input int cC, input bit eC);
    rowAB = 4'(rAB); colAB = 4'(cAB); enAB = eAB;
    rowC  = 3'(rC);  colC  = 5'(cC);  enC  = eC;
    @(posedge clk);
    modelStep(0, rAB, cAB, eAB);
    modelStep(1, rAB, cAB, eAB);
    modelStep(2, rC, cC, eC);
    @(negedge clk);
  endtask

  task automatic stepAB(input int r, input int c, input bit en, input string tag);
    int rC, cC;
    genSample(3, 5, rC, cC);
    applyStimulus(r, c, en, rC, cC, 1'b1);
    checkOutput(tag);
  endtask

  int kvCount;

  initial begin
    reset = 1'b0;
    rowAB = '0; colAB = '0; enAB = 1'b0;
    rowC  = '0; colC  = '0; enC  = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    reset = 1'b1;

    stepAB(1, 1, 1, "press1");
    stepAB(0, 0, 1, "rel");
    stepAB(2, 2, 1, "press5");
    cmp("seqDigits", 32'(digitsA), 32'h15);
    cmp("seqCount",  32'(countA),  32'd2);

    stepAB(0, 0, 1, "rel");
    kvCount = 0;
    for (int i = 0; i < 10; i++) begin
      stepAB(4'b0100, 4'b0100, 1, "hold9");
      kvCount += int'(keyValidA);
    end
    cmp("holdPulses", 32'(kvCount), 32'd1);
    cmp("holdCode",   32'(keyCodeA), 32'd9);

    stepAB(0, 0, 1, "rel");
    stepAB(4'b0011, 4'b0001, 1, "multiIdle");
    cmp("multiIdleErr", 32'(multiErrA), 32'd1);
    cmp("multiIdleDig", 32'(digitsA), 32'h59);
    stepAB(1, 1, 0, "enableLow");
    stepAB(1, 1, 1, "press1b");
    stepAB(4'b0010, 4'b0100, 1, "heldOther");
    stepAB(4'b0110, 4'b0001, 1, "multiHeld");
    stepAB(4'b0010, 4'b0100, 1, "stillHeld");
    cmp("heldDigits", 32'(digitsA), 32'h91);

    stepAB(0, 0, 1, "rel"); stepAB(1, 1, 1, "ovf1");
    stepAB(0, 0, 1, "rel"); stepAB(1, 2, 1, "ovf2");
    stepAB(0, 0, 1, "rel"); stepAB(1, 4, 1, "ovf3");
    stepAB(0, 0, 1, "rel"); stepAB(1, 8, 1, "ovfA");
    cmp("ovfDigitsB", 32'(digitsB), 32'h23A);
    cmp("ovfCountB",  32'(countB),  32'd3);

    stepAB(0, 0, 1, "rel"); stepAB(4, 1, 1, "clr7");
    stepAB(0, 0, 1, "rel"); stepAB(4, 2, 1, "clr8");
    stepAB(0, 0, 1, "rel"); stepAB(8, 1, 1, "clrE");
    cmp("clrDigits",   32'(digitsA),   ClearEn ? 32'h0 : 32'h8E);
    cmp("clrKeyCode",  32'(keyCodeA),  32'hE);
    cmp("clrKeyValid", 32'(keyValidA), 32'd1);

    stepAB(0, 0, 1, "rel"); stepAB(1, 2, 1, "rst2");
    stepAB(0, 0, 1, "rel"); stepAB(1, 4, 1, "rst3");
    cmp("preRstDigits", 32'(digitsA), 32'h23);
    #2 reset = 1'b0;
    #1 modelReset();
    checkOutput("asyncReset");
    @(negedge clk);
    reset = 1'b1;
    stepAB(1, 4, 1, "afterReset");
    cmp("afterResetPress", 32'(keyValidA), 32'd1);

    for (int n = 0; n < 300; n++) begin
      int rA, cA, rC, cC;
      genSample(4, 4, rA, cA);
      genSample(3, 5, rC, cC);
      applyStimulus(rA, cA, $urandom_range(0, 9) != 0, rC, cC, $urandom_range(0, 9) != 0);
      checkOutput("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
